ht_res_stat: RTL

- Sits directly downstream of the hash-table result producer, between the result stream and the user-side consumer.
- Re-times the result stream through a 2-entry skid buffer, so the valid/ready path is fully registered and throughput is 1 result/cycle.
- Counts every result delivered downstream, per result code plus a total, in saturating counters.
- Counters are exposed through a small registered read port with synchronous clear.

---
 rtl/ht_res_stat_pkg.sv | 23 ++
 rtl/ht_res_if.sv | 12 +
 rtl/ht_res_skid.sv | 82 ++++++++
 rtl/ht_res_stat.sv | 91 +++++++++
 4 files changed

// File: rtl/ht_res_stat_pkg.sv
// rtl/ht_res_stat_pkg.sv - hash-table result types and statistics address map
package ht_res_stat_pkg;

    typedef enum logic [2:0] {
        HT_RES_HIT      = 3'd0,
        HT_RES_MISS     = 3'd1,
        HT_RES_INSERTED = 3'd2,
        HT_RES_UPDATED  = 3'd3,
        HT_RES_DELETED  = 3'd4,
        HT_RES_FULL     = 3'd5,
        HT_RES_ERROR    = 3'd6
    } ht_rescode_t;

    typedef struct packed {
        ht_rescode_t rescode;
        logic [15:0] data;
    } ht_result_t;

    localparam int HT_RESCODE_CNT = 7;
    localparam int HT_STAT_ADDR_W = 3;
    localparam logic [HT_STAT_ADDR_W-1:0] HT_STAT_TOTAL_ADDR = 3'd7;

endpackage

// File: rtl/ht_res_if.sv
// rtl/ht_res_if.sv - valid/ready result stream carrying ht_result_t
interface ht_res_if;
    import ht_res_stat_pkg::*;

    ht_result_t result;
    logic       valid;
    logic       ready;

    modport master (output result, output valid, input ready);
    modport slave  (input result, input valid, output ready);

endinterface

// File: rtl/ht_res_skid.sv
// rtl/ht_res_skid.sv - 2-entry registered skid buffer for ht_result_t streams
module ht_res_skid
    import ht_res_stat_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  ht_result_t in_result_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output ht_result_t out_result_o,
    output logic       out_valid_o,
    input  logic       out_ready_i
);

    ht_result_t r_main;
    ht_result_t r_skid;
    logic       r_main_valid;
    logic       r_skid_valid;
    logic       r_in_ready;

    logic w_accept;
    logic w_drain;
    logic w_main_load_in;
    logic w_main_load_skid;
    logic w_skid_load;
    logic w_main_valid_nx;
    logic w_skid_valid_nx;

    always_comb begin
        w_accept         = in_valid_i && r_in_ready;
        w_drain          = r_main_valid && out_ready_i;
        w_main_load_in   = 1'b0;
        w_main_load_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_main_valid_nx  = r_main_valid;
        w_skid_valid_nx  = r_skid_valid;
        // in_ready is low whenever skid is occupied, so accept and skid refill never coincide
        if (!r_main_valid || w_drain) begin
            if (r_skid_valid) begin
                w_main_load_skid = 1'b1;
                w_main_valid_nx  = 1'b1;
                w_skid_valid_nx  = 1'b0;
            end else if (w_accept) begin
                w_main_load_in  = 1'b1;
                w_main_valid_nx = 1'b1;
            end else begin
                w_main_valid_nx = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_load     = 1'b1;
            w_skid_valid_nx = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_in_ready   <= !w_skid_valid_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_main_load_skid) begin
            r_main <= r_skid;
        end else if (w_main_load_in) begin
            r_main <= in_result_i;
        end
        if (w_skid_load) begin
            r_skid <= in_result_i;
        end
    end

    assign in_ready_o   = r_in_ready;
    assign out_result_o = r_main;
    assign out_valid_o  = r_main_valid;

endmodule

// File: rtl/ht_res_stat.sv
// rtl/ht_res_stat.sv - result stream re-timer with saturating per-rescode delivery counters
module ht_res_stat
    import ht_res_stat_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    ht_res_if.slave                   ht_res_in,
    ht_res_if.master                  ht_res_out,
    input  logic                      cnt_clear_i,
    input  logic [HT_STAT_ADDR_W-1:0] rd_addr_i,
    output logic [CNT_W-1:0]          rd_data_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt [HT_RESCODE_CNT];
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_rd_data;

    logic                      w_evt;
    logic [2:0]                w_code;
    logic [HT_RESCODE_CNT-1:0] w_hit;
    logic [CNT_W-1:0]          w_rd;

    ht_res_skid u_skid (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .in_result_i  (ht_res_in.result),
        .in_valid_i   (ht_res_in.valid),
        .in_ready_o   (ht_res_in.ready),
        .out_result_o (ht_res_out.result),
        .out_valid_o  (ht_res_out.valid),
        .out_ready_i  (ht_res_out.ready)
    );

    always_comb begin
        w_evt  = ht_res_out.valid && ht_res_out.ready;
        w_code = ht_res_out.result.rescode;
        w_hit  = '0;
        // out-of-range rescodes still count toward the total
        if (w_evt && (w_code < 3'(HT_RESCODE_CNT))) begin
            w_hit[w_code] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < HT_RESCODE_CNT; i++) begin
                r_cnt[i] <= '0;
            end
            r_total <= '0;
        end else begin
            for (int i = 0; i < HT_RESCODE_CNT; i++) begin
                if (cnt_clear_i) begin
                    r_cnt[i] <= w_hit[i] ? CNT_ONE : '0;
                end else if (w_hit[i] && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
            if (cnt_clear_i) begin
                r_total <= w_evt ? CNT_ONE : '0;
            end else if (w_evt && (r_total != CNT_MAX)) begin
                r_total <= r_total + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (rd_addr_i == HT_STAT_TOTAL_ADDR) begin
            w_rd = r_total;
        end else if (rd_addr_i < 3'(HT_RESCODE_CNT)) begin
            w_rd = r_cnt[rd_addr_i];
        end
    end

    // samples pre-update counter values, so a same-cycle event shows up one read later
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd;
        end
    end

    assign rd_data_o = r_rd_data;

endmodule
